// File: rtl/core_run_sequencer.sv
// Sequences the core through clock-on, reset release, run, reset assert, clock-off under host register control.
// Latency: bus response one cycle after request; START shows on clk_core_en_o the next cycle.
// Backpressure: none; every request is granted combinationally and answered exactly once.
module core_run_sequencer #(
    parameter int RST_CYCLES  = 8,
    parameter int GATE_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        core_done_i,
    output logic        clk_core_en_o,
    output logic        rst_n_core_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLK_ON = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam int PMAX = (RST_CYCLES > GATE_CYCLES) ? RST_CYCLES : GATE_CYCLES;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PW-1:0] RST_LAST  = PW'(RST_CYCLES - 1);
    localparam logic [PW-1:0] GATE_LAST = PW'(GATE_CYCLES - 1);

    state_e        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [31:0]   cycles, cycles_nxt, cycles_inc;
    logic [31:0]   timeout;
    logic          done_flag, tout_flag, done_nxt, tout_nxt;
    logic          set_done, set_tout;
    logic          clk_en_q, rst_n_q, irq_q, rvalid_q;
    logic [31:0]   rdata_q, rd_mux;

    logic [1:0] sel;
    logic       wr, start_wr, abort_wr, w1c_done, w1c_tout;

    // Only the word index is decoded; the remaining address bits are don't-care.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

    assign sel      = addr_i[3:2];
    assign wr       = req_i && we_i;
    assign start_wr = wr && (sel == 2'd0) && be_i[0] && wdata_i[0];
    assign abort_wr = wr && (sel == 2'd0) && be_i[0] && wdata_i[1];
    assign w1c_done = wr && (sel == 2'd1) && be_i[0] && wdata_i[3];
    assign w1c_tout = wr && (sel == 2'd1) && be_i[0] && wdata_i[4];

    assign cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        cycles_nxt = cycles;
        set_done   = 1'b0;
        set_tout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_wr) begin
                    state_nxt  = ST_CLK_ON;
                    phase_nxt  = '0;
                    cycles_nxt = '0;
                end
            end
            ST_CLK_ON: begin
                if (abort_wr) begin
                    state_nxt = ST_DRAIN;
                    phase_nxt = '0;
                end else if (phase == RST_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            ST_RUN: begin
                // The count includes this cycle, so the limit compares against the incremented value.
                cycles_nxt = cycles_inc;
                if (core_done_i) begin
                    state_nxt = ST_DRAIN;
                    phase_nxt = '0;
                    set_done  = 1'b1;
                end else if ((timeout != 32'd0) && (cycles_inc == timeout)) begin
                    state_nxt = ST_DRAIN;
                    phase_nxt = '0;
                    set_tout  = 1'b1;
                end else if (abort_wr) begin
                    state_nxt = ST_DRAIN;
                    phase_nxt = '0;
                end
            end
            ST_DRAIN: begin
                if (phase == GATE_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        done_nxt = set_done | (done_flag & ~w1c_done);
        tout_nxt = set_tout | (tout_flag & ~w1c_tout);
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            2'd1:    rd_mux = {27'd0, tout_flag, done_flag, 1'b0, state};
            2'd2:    rd_mux = timeout;
            2'd3:    rd_mux = cycles;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase     <= '0;
            cycles    <= '0;
            timeout   <= '0;
            done_flag <= 1'b0;
            tout_flag <= 1'b0;
            clk_en_q  <= 1'b0;
            rst_n_q   <= 1'b0;
            irq_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            phase     <= phase_nxt;
            cycles    <= cycles_nxt;
            done_flag <= done_nxt;
            tout_flag <= tout_nxt;
            // Core controls come from flops fed by the next state so the clock-gate enable never glitches.
            clk_en_q  <= (state_nxt != ST_IDLE);
            rst_n_q   <= (state_nxt == ST_RUN);
            irq_q     <= done_nxt | tout_nxt;
            rvalid_q  <= req_i;
            rdata_q   <= (req_i && !we_i) ? rd_mux : 32'd0;
            if (wr && (sel == 2'd2)) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) begin
                        timeout[8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
        end
    end

    assign gnt_o         = req_i;
    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign clk_core_en_o = clk_en_q;
    assign rst_n_core_o  = rst_n_q;
    assign irq_o         = irq_q;

endmodule
